// File: rtl/msi_snoop_pkg.sv
// msi_snoop_pkg: line-state, bus-op, FSM and event encodings for msi_snoop_ctrl.
// Defining MSI_SNOOP_MESI_EN turns on the E state (code 3).
package msi_snoop_pkg;
  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_M = 2'd2, ST_E = 2'd3;
  localparam logic [1:0] OP_NONE = 2'd0, OP_RDMISS = 2'd1, OP_WRMISS = 2'd2, OP_INV = 2'd3;
`ifdef MSI_SNOOP_MESI_EN
  localparam bit MESI_EN = 1'b1;
`else
  localparam bit MESI_EN = 1'b0;
`endif
  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_SNOOP, S_WB, S_RESP} fsm_t;
  typedef struct packed {
    logic rd_miss;
    logic wr_miss;
    logic inv;
    logic wb_block;
    logic wb_cache;
    logic mem_abort;
    logic err;
  } ev_t;
endpackage

// File: rtl/msi_line_next.sv
// msi_line_next: next state and events for one cache line, as requester or as snooper.
// Under MSI_SNOOP_MESI_EN code 3 is E; otherwise a decoded 3 is treated as I.
module msi_line_next
  import msi_snoop_pkg::*;
(
  input  logic       snoop_i,
  input  logic [1:0] st_i,
  input  logic       write_i,
  input  logic       hit_i,
  input  logic [1:0] op_i,
  output logic [1:0] st_o,
  output logic [6:0] ev_o,
  output logic       sharer_o
);
  logic [1:0] st;
  logic       hit;
  ev_t        ev;
  assign st   = (!MESI_EN && st_i == ST_E) ? ST_I : st_i;
  assign hit  = hit_i && st != ST_I;
  assign ev_o = ev;
  always_comb begin
    st_o     = st;
    ev       = '0;
    sharer_o = 1'b0;
    if (snoop_i) begin
      sharer_o     = op_i == OP_RDMISS && st != ST_I;
      st_o         = (op_i == OP_NONE || st == ST_I) ? st : (op_i == OP_RDMISS ? ST_S : ST_I);
      ev.wb_block  = st == ST_M && (op_i == OP_RDMISS || op_i == OP_WRMISS);
      ev.mem_abort = ev.wb_block;
      ev.err       = st == ST_M && op_i == OP_INV;
    end else if (!write_i) begin
      st_o        = hit ? st : ST_S;
      ev.rd_miss  = !hit && st != ST_M;
      ev.wb_block = !hit && st == ST_M;
    end else begin
      st_o        = ST_M;
      ev.inv      = hit && st == ST_S;
      ev.wr_miss  = !hit;
      ev.wb_cache = !hit && st == ST_M;
    end
  end
endmodule

// File: rtl/msi_snoop_ctrl.sv
// msi_snoop_ctrl: MSI coherence for NUM_CORES caches x NUM_LINES lines over one snooping bus.
// MSI_SNOOP_MESI_EN adds the E state; the default build is plain MSI.
module msi_snoop_ctrl
  import msi_snoop_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int NUM_LINES = 4,
  localparam int CW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1,
  localparam int LW = $clog2(NUM_LINES)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [CW-1:0]                    req_core_i,
  input  logic [LW-1:0]                    req_line_i,
  input  logic                             req_write_i,
  input  logic                             req_tag_hit_i,
  output logic                             resp_valid_o,
  output logic                             resp_err_o,
  output logic                             bus_read_miss_o,
  output logic                             bus_write_miss_o,
  output logic                             bus_invalidate_o,
  output logic                             wb_block_o,
  output logic                             wb_cache_o,
  output logic                             mem_abort_o,
  output logic [2*NUM_CORES*NUM_LINES-1:0] line_state_o
);
  fsm_t                           fsm_q;
  logic [2*NUM_CORES*NUM_LINES-1:0] ls_q;
  logic [CW-1:0]                  core_q;
  logic [LW-1:0]                  line_q;
  logic                           write_q, hit_q, resp_valid_q;
  ev_t                            ev_q, out_q, r_ev, snp_or, ev_snp;
  logic [1:0]                     r_st;
  logic [1:0]                     snp_st [NUM_CORES];
  logic [6:0]                     snp_ev [NUM_CORES];
  logic [NUM_CORES-1:0]           snp_shr;
  logic                           r_shr, shared, illegal;
  logic [1:0]                     op;
  int                             ridx;
  assign illegal = int'(core_q) >= NUM_CORES;
  assign ridx    = 2 * (int'(core_q) * NUM_LINES + int'(line_q));
  assign op      = ev_q.rd_miss ? OP_RDMISS : ev_q.wr_miss ? OP_WRMISS : ev_q.inv ? OP_INV : OP_NONE;
  msi_line_next u_req (
    .snoop_i(1'b0), .st_i(ls_q[ridx +: 2]), .write_i(write_q), .hit_i(hit_q), .op_i(OP_NONE),
    .st_o(r_st), .ev_o(r_ev), .sharer_o(r_shr)
  );
  // The requester's own snooper sees no bus op, so it just reports the LOOKUP result back.
  for (genvar c = 0; c < NUM_CORES; c++) begin : g_snp
    msi_line_next u_snp (
      .snoop_i(1'b1), .st_i(ls_q[2*(c*NUM_LINES+int'(line_q)) +: 2]), .write_i(write_q),
      .hit_i(hit_q), .op_i(CW'(c) == core_q ? OP_NONE : op),
      .st_o(snp_st[c]), .ev_o(snp_ev[c]), .sharer_o(snp_shr[c])
    );
  end
  always_comb begin
    snp_or = '0;
    for (int c = 0; c < NUM_CORES; c++) snp_or = ev_t'(snp_or | snp_ev[c]);
  end
  assign ev_snp = ev_t'(ev_q | snp_or);
  assign shared = |snp_shr | r_shr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= S_IDLE;
      ls_q         <= '0;
      core_q       <= '0;
      line_q       <= '0;
      write_q      <= 1'b0;
      hit_q        <= 1'b0;
      ev_q         <= '0;
      out_q        <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: if (req_valid_i) begin
          core_q  <= req_core_i;
          line_q  <= req_line_i;
          write_q <= req_write_i;
          hit_q   <= req_tag_hit_i;
          fsm_q   <= S_LOOKUP;
        end
        S_LOOKUP: if (illegal) begin
          out_q        <= ev_t'(7'b1);
          resp_valid_q <= 1'b1;
          fsm_q        <= S_RESP;
        end else begin
          ls_q[ridx +: 2] <= r_st;
          ev_q            <= r_ev;
          fsm_q           <= S_SNOOP;
        end
        S_SNOOP: begin
          for (int c = 0; c < NUM_CORES; c++) ls_q[2*(c*NUM_LINES+int'(line_q)) +: 2] <= snp_st[c];
          if (MESI_EN && ev_q.rd_miss && !shared) ls_q[ridx +: 2] <= ST_E;
          ev_q <= ev_snp;
          if (snp_or.wb_block) fsm_q <= S_WB;
          else begin
            out_q        <= ev_snp;
            resp_valid_q <= 1'b1;
            fsm_q        <= S_RESP;
          end
        end
        S_WB: begin
          out_q        <= ev_q;
          resp_valid_q <= 1'b1;
          fsm_q        <= S_RESP;
        end
        default: begin
          out_q        <= '0;
          resp_valid_q <= 1'b0;
          fsm_q        <= S_IDLE;
        end
      endcase
    end
  end
  assign req_ready_o      = fsm_q == S_IDLE;
  assign resp_valid_o     = resp_valid_q;
  assign resp_err_o       = out_q.err;
  assign bus_read_miss_o  = out_q.rd_miss;
  assign bus_write_miss_o = out_q.wr_miss;
  assign bus_invalidate_o = out_q.inv;
  assign wb_block_o       = out_q.wb_block;
  assign wb_cache_o       = out_q.wb_cache;
  assign mem_abort_o      = out_q.mem_abort;
  assign line_state_o     = ls_q;
endmodule

// File: tb/tb_msi_snoop_ctrl.sv
// tb_msi_snoop_ctrl: directed scoreboard bench for msi_snoop_ctrl with 3 cores x 4 lines.
// Expected latency, events and line states are queued at drive time and popped at resp_valid.
module tb_msi_snoop_ctrl;
  localparam int NC = 3, NL = 4, SW = 2 * NC * NL;
`ifdef MSI_SNOOP_MESI_EN
  localparam bit MESI = 1'b1;
`else
  localparam bit MESI = 1'b0;
`endif
  localparam logic [1:0] I = 2'd0, S = 2'd1, M = 2'd2, E = 2'd3;
  localparam logic [1:0] RS = MESI ? E : S;
  localparam logic [5:0] RD = 6'b100000, WR = 6'b010000, INV = 6'b001000;
  localparam logic [5:0] WBB = 6'b000100, WBC = 6'b000010, AB = 6'b000001;
  logic clk, rst_n, req_valid, req_ready, req_write, req_tag_hit;
  logic [1:0] req_core, req_line;
  logic resp_valid, resp_err, bus_read_miss, bus_write_miss, bus_invalidate;
  logic wb_block, wb_cache, mem_abort;
  logic [SW-1:0] line_state;
  logic [5:0] evs;
  typedef struct {
    string         tag;
    int            lat;
    logic          err;
    logic [5:0]    ev;
    logic [SW-1:0] ls;
  } exp_t;
  exp_t sb[$];
  logic [1:0] ex [NC][NL];
  int total, bad, resp_cnt;
  msi_snoop_ctrl #(.NUM_CORES(NC), .NUM_LINES(NL)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_core_i(req_core), .req_line_i(req_line), .req_write_i(req_write),
    .req_tag_hit_i(req_tag_hit), .resp_valid_o(resp_valid), .resp_err_o(resp_err),
    .bus_read_miss_o(bus_read_miss), .bus_write_miss_o(bus_write_miss),
    .bus_invalidate_o(bus_invalidate), .wb_block_o(wb_block), .wb_cache_o(wb_cache),
    .mem_abort_o(mem_abort), .line_state_o(line_state)
  );
  assign evs = {bus_read_miss, bus_write_miss, bus_invalidate, wb_block, wb_cache, mem_abort};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (resp_valid) resp_cnt <= resp_cnt + 1;
  function automatic logic [SW-1:0] pack();
    logic [SW-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++)
      for (int l = 0; l < NL; l++) v[2*(c*NL+l) +: 2] = ex[c][l];
    return v;
  endfunction
  task automatic clear_model();
    for (int c = 0; c < NC; c++)
      for (int l = 0; l < NL; l++) ex[c][l] = I;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk({tag, "_ready_timeout"}, 0, 1);
  endtask
  task automatic send(input string tag, input int c, input int l, input bit w, input bit h,
                      input logic [5:0] ev, input bit err, input int lat, input bit hold);
    exp_t e;
    int n;
    e.tag = tag;
    e.lat = lat;
    e.err = err;
    e.ev  = ev;
    e.ls  = pack();
    sb.push_back(e);
    wait_ready(tag);
    req_valid   = 1'b1;
    req_core    = 2'(c);
    req_line    = 2'(l);
    req_write   = w;
    req_tag_hit = h;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    chk({tag, "_busy"}, req_ready, 0);
    n = 1;
    while (!resp_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    e = sb.pop_front();
    chk({e.tag, "_lat"}, n, e.lat);
    chk({e.tag, "_err"}, resp_err, e.err);
    chk({e.tag, "_ev"}, evs, e.ev);
    chk({e.tag, "_ls"}, line_state, e.ls);
  endtask
  initial begin
    int snap;
    total = 0;
    bad = 0;
    resp_cnt = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_core = '0;
    req_line = '0;
    req_write = 1'b0;
    req_tag_hit = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_resp", resp_valid, 0);
    chk("rst_ls", line_state, 0);
    chk("rst_ev", {resp_err, evs}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ex[0][2] = RS;
    send("rd_c0l2", 0, 2, 0, 0, RD, 0, 3, 0);
    ex[0][2] = S; ex[1][2] = S;
    send("rd_c1l2", 1, 2, 0, 0, RD, 0, 3, 0);
    ex[0][2] = M; ex[1][2] = I;
    send("wrhit_c0l2", 0, 2, 1, 1, INV, 0, 3, 0);
    ex[0][1] = M;
    send("wrmiss_c0l1", 0, 1, 1, 0, WR, 0, 3, 0);
    ex[0][1] = S; ex[1][1] = S;
    send("rd_c1l1_wb", 1, 1, 0, 0, RD | WBB | AB, 0, 4, 0);
    ex[0][1] = M; ex[1][1] = I;
    send("wrhit_c0l1", 0, 1, 1, 1, INV, 0, 3, 0);
    ex[0][1] = I; ex[1][1] = M;
    send("wrmiss_c1l1_wb", 1, 1, 1, 0, WR | WBB | AB, 0, 4, 0);
    send("rdhit_c1l1_m", 1, 1, 0, 1, 6'b0, 0, 3, 0);
    ex[1][1] = S;
    send("rdconf_c1l1_m", 1, 1, 0, 0, WBB, 0, 3, 0);
    ex[1][1] = M;
    send("wrconf_c1l1_s", 1, 1, 1, 0, WR, 0, 3, 0);
    send("wrconf_c1l1_m", 1, 1, 1, 0, WR | WBC, 0, 3, 0);
    send("illegal_core", 3, 1, 1, 0, 6'b0, 1, 2, 0);
    ex[2][0] = RS;
    send("hold_c2l0", 2, 0, 0, 1, RD, 0, 3, 1);
    @(posedge clk);
    #1;
    snap = resp_cnt;
    repeat (8) @(posedge clk);
    #1;
    chk("hold_single_resp", resp_cnt, snap);
    chk("hold_idle_ready", req_ready, 1);
    wait_ready("rst_mid");
    req_valid = 1'b1;
    req_core = 2'd0;
    req_line = 2'd0;
    req_write = 1'b0;
    req_tag_hit = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    clear_model();
    chk("rst_mid_ls", line_state, pack());
    chk("rst_mid_resp", resp_valid, 0);
    chk("rst_mid_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    snap = resp_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_no_resp", resp_cnt, snap);
    ex[0][3] = RS;
    send("rd_c0l3_post_rst", 0, 3, 0, 0, RD, 0, 3, 0);
    ex[0][3] = M;
    send("wrhit_c0l3", 0, 3, 1, 1, MESI ? 6'b0 : INV, 0, 3, 0);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
